// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - start/busy/done request bus and HI/LO readout of the multiply/divide unit
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; MDU_SINGLE_CYCLE_MULT_EN selects a combinational multiplier
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  mult_div_unit_if.slave    bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;        // mult: {partial sum, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;      // |multiplicand| or |divisor|
  logic               is_mul_q, is_mul_d;
  logic               neg_q, neg_d;        // operand signs differ
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;    // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_step, div_step, acc_step, mul_res;
  logic [WIDTH-1:0]   quot, rem;
`ifdef MDU_SINGLE_CYCLE_MULT_EN
  logic [2*WIDTH-1:0] prod;
`endif

  // One shift-add or restoring-divide step on the accumulator, plus sign-corrected results
  always_comb begin
    signed_op = ~bus.op[0];
    a_neg     = signed_op & bus.a[WIDTH-1];
    b_neg     = signed_op & bus.b[WIDTH-1];
    a_abs     = a_neg ? -bus.a : bus.a;
    b_abs     = b_neg ? -bus.b : bus.b;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_step  = {mul_sum, acc_q[WIDTH-1:1]};

    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    div_step  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    acc_step  = is_mul_q ? mul_step : div_step;
    mul_res   = neg_q ? -acc_step : acc_step;
    quot      = acc_step[WIDTH-1:0];
    rem       = acc_step[2*WIDTH-1:WIDTH];
`ifdef MDU_SINGLE_CYCLE_MULT_EN
    // Sign-extending to 2*WIDTH makes one truncated multiply serve both MULT and MULTU
    prod      = {{WIDTH{a_neg}}, bus.a} * {{WIDTH{b_neg}}, bus.b};
`endif
  end

  // Next state: accept in IDLE/DONE, iterate in RUN, write HI/LO on the final step
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_mul_d  = is_mul_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    a_raw_d   = a_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          if (is_mul_q) begin
            hi_d = mul_res[2*WIDTH-1:WIDTH];
            lo_d = mul_res[WIDTH-1:0];
          end else if (dz_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = neg_rem_q ? -rem : rem;
            lo_d = neg_q ? -quot : quot;
          end
        end
      end
      default: begin
        state_d = IDLE;
        if (bus.start) begin
          case (bus.op[2:1])
            2'b00, 2'b01: begin
`ifdef MDU_SINGLE_CYCLE_MULT_EN
              if (bus.op[2:1] == 2'b00) begin
                state_d = DONE;
                hi_d    = prod[2*WIDTH-1:WIDTH];
                lo_d    = prod[WIDTH-1:0];
              end else begin
`else
              begin
`endif
                state_d   = RUN;
                cnt_d     = CW'(WIDTH);
                is_mul_d  = (bus.op[2:1] == 2'b00);
                acc_d     = {{WIDTH{1'b0}}, (is_mul_d ? b_abs : a_abs)};
                opnd_d    = is_mul_d ? a_abs : b_abs;
                neg_d     = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                dz_d      = (bus.b == '0);
                a_raw_d   = bus.a;
              end
            end
            2'b10: begin
              if (bus.op[0]) lo_d = bus.a;
              else           hi_d = bus.a;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset drops any run in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_mul_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_mul_q  <= is_mul_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      a_raw_q   <= a_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized scoreboard bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus ();
  mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
  } exp_t;

  exp_t         sb[$];
  exp_t         got;
  int           passed = 0;
  int           total  = 0;
  int           cyc    = 0;
  logic [W-1:0] m_hi   = '0;
  logic [W-1:0] m_lo   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: HI/LO from plain signed/unsigned arithmetic
  function automatic logic [63:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sbv;
    int     q, r;
    case (op)
      3'd0: begin
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        return 64'(sa * sbv);
      end
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op);
`ifdef MDU_SINGLE_CYCLE_MULT_EN
    if (op[2:1] == 2'b00) return 0;
`endif
    return W;
  endfunction

  // Monitor: every done pulse must match the oldest expected result and its cycle
  always @(negedge clk) begin
    if (!reset && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        got = sb.pop_front();
        check("result_hi", bus.hi, got.hi);
        check("result_lo", bus.lo, got.lo);
        check("done_cycle", cyc, got.due);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_done);
    int          n;
    logic [63:0] r;
    exp_t        e;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_not_busy", bus.busy, 0);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (op[2] == 1'b0) begin
      r = model(op, a, b);
      if (expect_done) begin
        e.hi  = r[63:32];
        e.lo  = r[31:0];
        e.due = cyc + 1 + latency(op);
        sb.push_back(e);
        m_hi = r[63:32];
        m_lo = r[31:0];
      end
    end else if (op[1] == 1'b0) begin
      if (op[0]) m_lo = a;
      else       m_hi = a;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    if (op[2] == 1'b1) begin
      check("mt_noop_hi", bus.hi, m_hi);
      check("mt_noop_lo", bus.lo, m_lo);
      check("mt_noop_busy", bus.busy, 0);
      check("mt_noop_done", bus.done, 0);
    end else if (latency(op) > 0) begin
      check("busy_after_accept", bus.busy, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int           n;
    int           dones;
    logic [2:0]   op;
    logic [W-1:0] a, b;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_hi", bus.hi, 0);
    check("reset_lo", bus.lo, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);

    // Abort a DIVU in its 10th busy cycle
    issue(3'd3, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    check("abort_busy_before", bus.busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_hi", bus.hi, 0);
    check("abort_lo", bus.lo, 0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort_no_done", dones, 0);

    // Directed cases
    issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
    issue(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(3'd3, 32'd100, 32'd7, 1'b1);
    issue(3'd3, 32'h1234_5678, 32'd0, 1'b1);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(3'd2, 32'hFFFF_FFF0, 32'd0, 1'b1);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    // A start while busy is dropped
`ifdef MDU_SINGLE_CYCLE_MULT_EN
    issue(3'd3, 32'h0001_2345, 32'h0000_0567, 1'b1);
`else
    issue(3'd1, 32'h0001_2345, 32'h0000_5678, 1'b1);
`endif
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd1;
    bus.a     = 32'hFFFF_0000;
    bus.b     = 32'h0000_FFFF;
    @(negedge clk);
    bus.start = 1'b0;

    // MTHI issued in the DONE cycle of a multiply
    issue(3'd1, 32'h0000_1111, 32'h0000_2222, 1'b1);
    n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_done", bus.done, 1);
    bus.start = 1'b1;
    bus.op    = 3'd4;
    bus.a     = 32'hDEAD_BEEF;
    m_hi      = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("mthi_done_hi", bus.hi, 32'hDEAD_BEEF);
    check("mthi_done_lo", bus.lo, m_lo);
    check("mthi_done_idle", bus.done, 0);

    // Randomized mix, often back-to-back in the DONE cycle
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(op, a, b, 1'b1);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    repeat (W + 10) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execute stage of the MIPS32 datapath. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO with a start/busy/done handshake. The controller stalls on `busy` and reads `hi`/`lo` directly for MFHI/MFLO.

## Interface
- `WIDTH`, 32, operand and HI/LO width; must be ≥ 4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- `a`  in  WIDTH  rs operand (dividend / multiplicand / MTxx source).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `busy`  out  1  iteration in progress; new `start` is ignored.
- `done`  out  1  one-cycle pulse; `hi`/`lo` now hold the new result.
- `hi`  out  WIDTH  HI register (product upper half / remainder).
- `lo`  out  WIDTH  LO register (product lower half / quotient).

## Operation
- FSM states: IDLE, RUN, DONE. `busy` = (state==RUN).
- Accept: `start`=1 and `busy`=0 (IDLE or DONE) at a rising edge.
  - `op`, `a`, `b` are latched at that edge. Later input changes have no effect.
- MTHI/MTLO: at the accept edge, write `hi`<=`a` (or `lo`<=`a`). Stay in IDLE. No `busy`, no `done`.
- No-op codes: ignored, no state change.
- MULT/MULTU/DIV/DIVU: go to RUN and load the iteration counter with WIDTH.
- Signed ops (MULT, DIV):
  - Take the absolute value of each operand and iterate unsigned.
  - Sign-correct at writeback: product/quotient are negated if the operand signs differ.
  - Remainder takes the sign of the dividend (`a`).
- Multiply: shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator. `hi`={upper}, `lo`={lower}.
- Divide: restoring, one quotient bit per cycle. `lo`=quotient, `hi`=remainder.
- Divide by zero (`b`=0): run the full WIDTH cycles. Result is `lo`=all ones, `hi`=`a` (raw, unsigned and signed alike).
- Signed overflow (`a`=most negative, `b`=−1): `lo`=most negative, `hi`=0 (two's-complement wrap).
- RUN→DONE when the counter reaches 0. `hi`/`lo` are written on that edge.
- DONE→RUN if a new mult/div is accepted. DONE→IDLE otherwise. MTxx accepted in DONE takes effect and goes to IDLE.
- `hi`/`lo` hold their values while in RUN (old contents remain readable).

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
- `reset` mid-operation aborts immediately. The partial result is discarded and no `done` is issued.
- Mult/div accepted at edge t0:
  - `busy`=1 for cycles t0+1 … t0+WIDTH.
  - `hi`/`lo` are written at edge t0+WIDTH.
  - `done`=1 and `busy`=0 during cycle t0+WIDTH+1 (WIDTH=32 → 32 busy cycles, done in cycle 33).
- Back-to-back: a `start` in the DONE cycle is accepted, so `done` and the next `busy` never overlap.
- MTHI/MTLO: `hi`/`lo` are visible in the cycle after the accept edge.
- `start` while `busy`=1: ignored entirely and not queued.

## Configuration
- `MDU_SINGLE_CYCLE_MULT_EN` defined:
  - MULT/MULTU use a combinational WIDTH×WIDTH multiplier.
  - Result is written at the accept edge, state goes directly to DONE, `done` is pulsed in cycle t0+1, and `busy` is never asserted.
  - Divide is unchanged.
- Undefined: all multiplies are iterative with WIDTH-cycle latency, as above.

## Test plan
- Reset then idle: `hi`=`lo`=0, `busy`=`done`=0. Assert `reset` in the 10th RUN cycle of a DIVU → no `done`, `hi`=`lo`=0.
- MULT a=0xFFFFFFFE (−2), b=0x00000003 → `done` in cycle 33, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. MULTU with the same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV a=−7 (0xFFFFFFF9), b=2 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1). DIVU a=100, b=7 → `lo`=14, `hi`=2.
- Boundaries:
  - DIVU a=0x12345678, b=0 → `lo`=0xFFFFFFFF, `hi`=0x12345678.
  - DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Handshake:
  - `start` MULTU pulsed again mid-RUN with different operands → ignored, first result only.
  - MTHI a=0xDEADBEEF in the DONE cycle → `hi`=0xDEADBEEF next cycle, `lo` keeps the product.
- With `MDU_SINGLE_CYCLE_MULT_EN`: MULTU 0xFFFFFFFF×0xFFFFFFFF → `busy` never asserted, `done` in cycle t0+1, `hi`=0xFFFFFFFE, `lo`=0x00000001.
